sram_sp_bytemask: RTL and testbench
===================================

Name: sram_sp_bytemask

Overview:
- Parametrised single-port synchronous SRAM block; successor to the fixed 16Kx32 word-only memory.
- Adds configurable data width, depth and base address, plus per-byte write strobes.
- Adds a valid/ready request channel and a held valid/ready response channel with an error flag for out-of-range or misaligned accesses.
- Sits between the core load/store or fetch unit and on-chip memory; instantiated once per memory region.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8 and at least 8.
- DEPTH, 16384, number of DATA_W words; must be a power of two.
- ADDR_W, 32, byte-address width.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH*DATA_W/8.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request this cycle.
- req_wen_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  write data.
- req_wstrb_i  in  DATA_W/8  byte write enables; bit k covers bits [8k+7:8k].
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
- rsp_err_o  out  1  access rejected.

Behaviour:
- Clock and reset: single clock clk_i. rst_i is asynchronous and active-high.
- Reset values: rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. req_ready_o=0 while rst_i is high. Array contents are not reset and are preserved across reset.
- Decode: BW=DATA_W/8, OFF=log2(BW).
  - err if req_addr_i < BASE_ADDR, or (req_addr_i-BASE_ADDR)>>OFF >= DEPTH, or req_addr_i[OFF-1:0] != 0 (OFF=0 disables the alignment check).
  - index = (req_addr_i-BASE_ADDR)>>OFF, truncated to log2(DEPTH) bits.
- Accept: req_valid_i && req_ready_o. req_ready_o = !rsp_valid_o || rsp_ready_i (combinational, no bubble between back-to-back requests).
- Write accept, no error: at the edge, each byte k with req_wstrb_i[k]=1 is written; other bytes are unchanged. wstrb=0 is a legal no-op write that still responds.
- Read accept, no error: the array word is latched into rsp_rdata_o at the accept edge (synchronous read).
- Error accept: array untouched; rsp_err_o=1, rsp_rdata_o=0.
- Latency: response valid exactly 1 cycle after the accept edge. Throughput is 1 request/cycle when rsp_ready_i=1.
- Response hold: while rsp_valid_o=1 && rsp_ready_i=0, rsp_rdata_o and rsp_err_o are stable and no new request is accepted.
- Response update on the rising edge:
  - accept → rsp_valid_o=1 with the new payload.
  - else if rsp_ready_i → rsp_valid_o=0; payload may hold.
  - else → hold.
- Ordering: responses return in request order. A write accepted at cycle N is visible to a read accepted at N+1.
- Only one request per cycle, so there is no read/write port conflict.
- Reset mid-operation: the pending response is dropped (rsp_valid_o=0 immediately). A write accepted at the same edge as reset assertion is not guaranteed.
- X handling: req_* may be X when req_valid_i=0 without affecting state.
- Implementation: behavioural memory array inferable as block RAM, with byte-lane write enables and one registered read port.

Test Plan:
- Full-word write/read: write addr 0x0000_0010, wdata 0xDEADBEEF, wstrb 0xF; read 0x10 with rsp_ready_i=1 → write rsp (rdata=0, err=0) 1 cycle later; read rsp 0xDEADBEEF 1 cycle after its accept; back-to-back with req_ready_o held at 1.
- Byte strobes: after the above, write 0x10 wdata 0x11223344 wstrb 0b0101 → read returns 0xDE22BE44. Write with wstrb 0 → read unchanged, write still responds.
- Errors (BASE_ADDR=0x8000_0000): read 0x7FFF_FFFC, read 0x8001_0000, write 0x8000_0002 → each rsp_err_o=1, rdata=0; a following read of 0x8000_0000 shows no corruption.
- Backpressure: issue 3 reads to words holding 1,2,3 with rsp_ready_i low for 4 cycles → rsp_valid_o=1, rdata=1 stable, req_ready_o=0. Release → 1,2,3 delivered in order, one per cycle.
- Reset mid-stream: assert rst_i while rsp_valid_o=1 → rsp_valid_o/rdata/err go 0 asynchronously and req_ready_o=0. After release, reading a pre-reset written address returns the old data.
- Parameter sweep: DATA_W=64, DEPTH=256 → 8-bit strobes, alignment on addr[2:0]; word 255 ok, word 256 err; random write/read versus reference model for 10k transactions.

Source files
------------

// File: rtl/sram_sp_bytemask.sv
// sram_sp_bytemask: single-port synchronous SRAM with per-byte write strobes.
// Requests arrive on a valid/ready channel. Each request produces exactly one
// response on a held valid/ready channel, one cycle after it is accepted.
// Requests that fall outside the mapped window, or that are not aligned to a
// word, are rejected with rsp_err_o. Array contents survive reset.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The producer keeps its payload stable while valid is high and ready
// is low. req_ready_o is combinational: it is high when there is no response
// pending, or when the pending response is consumed in the same cycle.
module sram_sp_bytemask #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16384,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o
);

  localparam int                BW         = DATA_W / 8;
  localparam int                OFF        = $clog2(BW);
  localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BW - 1);
  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              rsp_rd_q,    rsp_rd_d;

  logic [ADDR_W-1:0] offs_d;
  logic [ADDR_W-1:0] word_d;
  logic [IDX_W-1:0]  idx_d;
  logic              err_d;
  logic              accept;
  logic              wr_en;
  logic              rd_en;

  // Address decode: word index relative to the window, plus the reject flag.
  // The alignment mask is zero for byte-wide memories, which disables that check.
  always_comb begin
    offs_d = req_addr_i - BASE_ADDR;
    word_d = offs_d >> OFF;
    idx_d  = word_d[IDX_W-1:0];
    err_d  = (req_addr_i < BASE_ADDR)
           | ({1'b0, word_d} >= DEPTH_L)
           | ((req_addr_i & ALIGN_MASK) != '0);
  end

  // Accept logic: a new request may enter whenever the response slot frees up.
  always_comb begin
    req_ready_o = !rst_i && (!rsp_valid_q || rsp_ready_i);
    accept      = req_valid_i && req_ready_o;
    wr_en       = accept && req_wen_i && !err_d;
    rd_en       = accept && !req_wen_i && !err_d;
  end

  // Byte-lane writes into the array; no reset so contents persist.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < BW; k++) begin
        if (req_wstrb_i[k]) begin
          mem_q[idx_d][8*k +: 8] <= req_wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Registered read port; only loads on an accepted, valid read, so it also
  // serves as the held read payload.
  always_ff @(posedge clk_i) begin
    if (rd_en) begin
      rd_data_q <= mem_q[idx_d];
    end
  end

  // Next response state: load on accept, retire on consume, otherwise hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rd_d    = rsp_rd_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_d;
      rsp_rd_d    = !req_wen_i && !err_d;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response control registers; reset drops any pending response at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // Read data is only presented for successful reads; writes and errors show 0.
  always_comb begin
    rsp_valid_o = rsp_valid_q;
    rsp_err_o   = rsp_err_q;
    rsp_rdata_o = rsp_rd_q ? rd_data_q : '0;
  end

endmodule

// File: tb/tb_sram_sp_bytemask.sv
// Bench for sram_sp_bytemask (64-bit words, 256 deep, window at 0x8000_0000).
// An array model of the memory predicts every response; responses are
// scored in order from an expected queue. Directed phases cover strobes,
// errors, backpressure and reset; a random phase runs 10k transactions.
module tb_sram_sp_bytemask;

  localparam int          DW   = 64;
  localparam int          BWB  = DW / 8;
  localparam int          DEP  = 256;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wen = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BWB-1:0] req_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] ref_mem [DEP];
  logic [DW:0]   last_rsp = '0;
  logic          pend_acc = 1'b0;
  logic          held = 1'b0;
  logic [DW:0]   held_pl = '0;
  logic          bp_rand = 1'b0;

  sram_sp_bytemask #(
    .DATA_W   (DW),
    .DEPTH    (DEP),
    .ADDR_W   (32),
    .BASE_ADDR(BASE)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_wen_i  (req_wen),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: window/alignment rule in plain arithmetic, array of words.
  task automatic model_access(input logic wen, input logic [31:0] addr,
                              input logic [DW-1:0] wd, input logic [BWB-1:0] ws);
    longint unsigned a = addr;
    longint unsigned b = BASE;
    logic [DW-1:0] m;
    int i;
    if (a < b || a >= b + DEP * BWB || (a % BWB) != 0) begin
      exp_q.push_back({1'b1, {DW{1'b0}}});
    end else begin
      i = int'((a - b) / BWB);
      if (wen) begin
        for (int k = 0; k < BWB; k++) m[8*k +: 8] = {8{ws[k]}};
        ref_mem[i] = (ref_mem[i] & ~m) | (wd & m);
        exp_q.push_back({1'b0, {DW{1'b0}}});
      end else begin
        exp_q.push_back({1'b0, ref_mem[i]});
      end
    end
  endtask

  // Scoreboard / protocol monitor, sampling on the falling edge.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst) begin
      pend_acc = 1'b0;
      held     = 1'b0;
    end else begin
      check_eq("ready_rule", DW'(req_ready), DW'(!rsp_valid || rsp_ready));
      if (pend_acc) check_eq("latency", DW'(rsp_valid), 1);
      if (held) begin
        check_eq("hold_valid", DW'(rsp_valid), 1);
        check_eq("hold_payload", {rsp_err, rsp_rdata}, held_pl);
      end
      if (rsp_valid && rsp_ready) begin
        last_rsp = {rsp_err, rsp_rdata};
        if (exp_q.size() == 0) begin
          check_eq("spurious_rsp", DW'(rsp_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp", {rsp_err, rsp_rdata}, e);
        end
      end
      pend_acc = req_valid && req_ready;
      if (pend_acc) model_access(req_wen, req_addr, req_wdata, req_wstrb);
      held    = rsp_valid && !rsp_ready;
      held_pl = {rsp_err, rsp_rdata};
    end
  end

  // Random response backpressure during the random phase.
  always @(posedge clk) begin
    #1;
    if (bp_rand) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // Driver tasks (called at posedge+1)
  task automatic send(input logic wen, input logic [31:0] addr,
                      input logic [DW-1:0] wd, input logic [BWB-1:0] ws);
    int n = 0;
    logic acc = 1'b0;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_eq("req_accept", DW'(acc), 1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [DW-1:0] wd, input logic [BWB-1:0] ws);
    send(1'b1, addr, wd, ws);
  endtask

  task automatic rd(input logic [31:0] addr);
    send(1'b0, addr, {$urandom, $urandom}, BWB'($urandom));
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_wen   = 'x;
    req_addr  = 'x;
    req_wdata = 'x;
    req_wstrb = 'x;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain", DW'(exp_q.size()), 0);
  endtask

  initial begin
    logic [31:0] a;
    int r;

    // Reset state
    #1;
    check_eq("rst_valid", DW'(rsp_valid), 0);
    check_eq("rst_ready", DW'(req_ready), 0);
    check_eq("rst_payload", {rsp_err, rsp_rdata}, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill every word so later partial writes have a known background.
    for (int i = 0; i < DEP; i++) wr(BASE + 32'(i * BWB), {$urandom, $urandom}, '1);
    drain();

    // Full-word write then back-to-back read
    wr(BASE + 32'h10, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    rd(BASE + 32'h10);
    drain();
    check_eq("full_word", DW'(last_rsp[31:0]), DW'(32'hDEAD_BEEF));

    // Byte strobes, and the zero-strobe no-op write
    wr(BASE + 32'h10, 64'h0000_0000_1122_3344, 8'b0000_0101);
    rd(BASE + 32'h10);
    drain();
    check_eq("strobe_merge", DW'(last_rsp[31:0]), DW'(32'hDE22_BE44));
    wr(BASE + 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    rd(BASE + 32'h10);
    drain();
    check_eq("strobe_zero", DW'(last_rsp[31:0]), DW'(32'hDE22_BE44));

    // Errors and window boundaries
    rd(32'h7FFF_FFFC);
    drain();
    check_eq("err_below", last_rsp, {1'b1, {DW{1'b0}}});
    rd(32'h8001_0000);
    wr(32'h8000_0002, '1, '1);
    drain();
    check_eq("err_misalign_wr", last_rsp, {1'b1, {DW{1'b0}}});
    wr(BASE + 32'h7F8, 64'h0123_4567_89AB_CDEF, '1);
    rd(BASE + 32'h7F8);
    drain();
    check_eq("word_last", last_rsp, {1'b0, 64'h0123_4567_89AB_CDEF});
    rd(BASE + 32'h800);
    drain();
    check_eq("word_past_end", DW'(last_rsp[DW]), 1);
    rd(BASE);
    drain();

    // Backpressure: three reads queued behind a stalled response
    wr(BASE + 32'h20, 64'd1, '1);
    wr(BASE + 32'h28, 64'd2, '1);
    wr(BASE + 32'h30, 64'd3, '1);
    drain();
    rsp_ready = 1'b0;
    fork
      begin
        rd(BASE + 32'h20);
        rd(BASE + 32'h28);
        rd(BASE + 32'h30);
        idle();
      end
      begin
        @(posedge clk);
        #1;
        repeat (4) begin
          @(negedge clk);
          check_eq("bp_valid", DW'(rsp_valid), 1);
          check_eq("bp_rdata", {rsp_err, rsp_rdata}, {1'b0, 64'd1});
          check_eq("bp_ready", DW'(req_ready), 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    drain();
    check_eq("bp_last", last_rsp, {1'b0, 64'd3});

    // Reset with a response pending; array must survive.
    rsp_ready = 1'b0;
    rd(BASE + 32'h28);
    idle();
    check_eq("pre_rst_valid", DW'(rsp_valid), 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", DW'(rsp_valid), 0);
    check_eq("mid_rst_payload", {rsp_err, rsp_rdata}, 0);
    check_eq("mid_rst_ready", DW'(req_ready), 0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rd(BASE + 32'h20);
    drain();
    check_eq("post_rst_data", last_rsp, {1'b0, 64'd1});

    // Random traffic against the model
    bp_rand = 1'b1;
    for (int t = 0; t < 10000; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
      r = $urandom_range(0, 15);
      if (r == 0) a = $urandom;
      else if (r == 1) a = BASE + 32'($urandom_range(0, DEP * BWB - 1)) | 32'h1;
      else if (r == 2) a = BASE + 32'(DEP * BWB) + 32'($urandom_range(0, 7) * BWB);
      else a = BASE + 32'($urandom_range(0, DEP - 1) * BWB);
      send(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, BWB'($urandom));
    end
    idle();
    @(posedge clk);
    bp_rand = 1'b0;
    #2;
    rsp_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
